step_clock_ctrl: RTL and testbench

STEP_CLOCK_CTRL -- requirements
Module: step_clock_ctrl

---
 rtl/step_clock_ctrl.sv | 124 ++++++++++++
 tb/tb_step_clock_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/step_clock_ctrl.sv
// Single-step clock controller: synchronizes and debounces the step button
// and mode select, then gates the core clock enable one pulse per press.
module step_clock_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_step,
  input  logic             clk_select,
  output logic             cpu_en,
  output logic             step_mode,
  output logic [CNT_W-1:0] step_count,
  output logic             busy
);

  localparam logic [7:0] DB_LIM = 8'(DEBOUNCE_CYCLES);

  typedef enum logic [2:0] {
    INIT,
    FREE,
    STEP_IDLE,
    STEP_PULSE,
    STEP_HOLD
  } state_t;

  logic             step_s1_q, step_s2_q;
  logic             sel_s1_q, sel_s2_q;
  logic [7:0]       db_cnt_q, db_cnt_d;
  logic             btn_db_q, btn_db_d;
  state_t           state_q, state_d;
  logic             cpu_en_q, busy_q;
  logic [CNT_W-1:0] step_cnt_q;

  // Two-flop synchronizers for both raw asynchronous inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      step_s1_q <= 1'b0;
      step_s2_q <= 1'b0;
      sel_s1_q  <= 1'b0;
      sel_s2_q  <= 1'b0;
    end else begin
      step_s1_q <= clk_step;
      step_s2_q <= step_s1_q;
      sel_s1_q  <= clk_select;
      sel_s2_q  <= sel_s1_q;
    end
  end

  // Debounce: count consecutive disagreeing samples, flip on reaching limit
  always_comb begin
    db_cnt_d = '0;
    btn_db_d = btn_db_q;
    if (step_s2_q != btn_db_q) begin
      if (db_cnt_q + 8'd1 == DB_LIM) begin
        btn_db_d = ~btn_db_q;
      end else begin
        db_cnt_d = db_cnt_q + 8'd1;
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt_q <= '0;
      btn_db_q <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      btn_db_q <= btn_db_d;
    end
  end

  // Next-state logic; leaving step mode wins over everything past INIT
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT: begin
        if (!sel_s2_q)     state_d = FREE;
        else if (btn_db_q) state_d = STEP_HOLD;
        else               state_d = STEP_IDLE;
      end
      FREE: begin
        if (sel_s2_q)
          state_d = btn_db_q ? STEP_HOLD : STEP_IDLE;
      end
      STEP_IDLE: begin
        if (!sel_s2_q)     state_d = FREE;
        else if (btn_db_q) state_d = STEP_PULSE;
      end
      STEP_PULSE: begin
        if (!sel_s2_q) state_d = FREE;
        else           state_d = STEP_HOLD;
      end
      STEP_HOLD: begin
        if (!sel_s2_q)      state_d = FREE;
        else if (!btn_db_q) state_d = STEP_IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  // State register with Moore outputs registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      cpu_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cpu_en_q <= (state_d == FREE) || (state_d == STEP_PULSE);
      busy_q   <= (state_d == STEP_HOLD);
      if (state_d == STEP_PULSE && state_q != STEP_PULSE)
        step_cnt_q <= step_cnt_q + CNT_W'(1);
    end
  end

  assign cpu_en     = cpu_en_q;
  assign busy       = busy_q;
  assign step_mode  = sel_s2_q;
  assign step_count = step_cnt_q;

endmodule

// File: tb/tb_step_clock_ctrl.sv
// Bench for step_clock_ctrl: directed presses, a scoreboard of expected
// step pulses (edge index and count) and a monitor that pops on each pulse.
module tb_step_clock_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_step = 1'b0;
  logic       clk_select = 1'b0;
  logic       cpu_en;
  logic       step_mode;
  logic [3:0] step_count;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [3:0] exp_cnt = 4'd0;

  typedef struct {
    int         at;
    logic [3:0] cnt;
  } exp_t;
  exp_t sb[$];

  step_clock_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_step  (clk_step),
    .clk_select(clk_select),
    .cpu_en    (cpu_en),
    .step_mode (step_mode),
    .step_count(step_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at edge %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic edges(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press for 'hold' sampled edges, release for 'rel' cycles
  task automatic press(int hold, int rel, bit expect_pulse);
    @(negedge clk);
    clk_step = 1'b1;
    if (expect_pulse) begin
      exp_t e;
      exp_cnt = exp_cnt + 4'd1;
      e.at  = cyc + 7;
      e.cnt = exp_cnt;
      sb.push_back(e);
    end
    repeat (hold) @(negedge clk);
    clk_step = 1'b0;
    repeat (rel) @(negedge clk);
  endtask

  // Monitor: every rising cpu_en in step mode must match the scoreboard
  initial begin
    logic prev_en;
    bit   wchk;
    prev_en = 1'b0;
    wchk    = 0;
    forever begin
      @(posedge clk);
      #1;
      if (wchk) begin
        checks++;
        if (cpu_en) begin
          errors++;
          $display("FAIL pulse_width: cpu_en still %0b one edge later", cpu_en);
        end
        wchk = 0;
      end
      if (cpu_en && !prev_en && step_mode) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: pulse at edge %0d count %0d",
                   cyc, step_count);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.at != cyc || e.cnt != step_count) begin
            errors++;
            $display("FAIL pulse: edge %0d count %0d expected edge %0d count %0d",
                     cyc, step_count, e.at, e.cnt);
          end
        end
        wchk = 1;
      end
      prev_en = cpu_en;
    end
  end

  initial begin
    int m;
    int budget;

    edges(3);
    chk("rst_cpu_en", 32'(cpu_en), 0);
    chk("rst_step_mode", 32'(step_mode), 0);
    chk("rst_count", 32'(step_count), 0);
    chk("rst_busy", 32'(busy), 0);

    @(negedge clk);
    rst = 1'b0;
    #1 chk("rel_en_low", 32'(cpu_en), 0);
    edges(2);
    chk("free_en", 32'(cpu_en), 1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      clk_step = ((i / 6) % 2) == 1;
      edges(1);
      chk("free_cont", 32'(cpu_en), 1);
    end
    chk("free_count", 32'(step_count), 0);
    @(negedge clk);
    clk_step = 1'b0;
    repeat (10) @(negedge clk);

    clk_select = 1'b1;
    edges(1);
    chk("sel_e1", 32'(step_mode), 0);
    edges(1);
    chk("sel_e2", 32'(step_mode), 1);
    chk("sel_e2_en", 32'(cpu_en), 1);
    edges(1);
    chk("sel_e3_en", 32'(cpu_en), 0);

    begin
      exp_t e;
      @(negedge clk);
      clk_step = 1'b1;
      exp_cnt = exp_cnt + 4'd1;
      e.at  = cyc + 7;
      e.cnt = exp_cnt;
      sb.push_back(e);
      repeat (20) @(negedge clk);
      chk("hold_busy", 32'(busy), 1);
      clk_step = 1'b0;
      m = cyc;
      edges(6);
      chk("rel_busy_m6", 32'(busy), 1);
      edges(1);
      chk("rel_busy_m7", 32'(busy), 0);
      chk("count_1", 32'(step_count), 1);
    end

    press(3, 15, 0);
    chk("glitch_count", 32'(step_count), 1);
    press(4, 15, 1);
    chk("min_press_count", 32'(step_count), 2);

    @(negedge clk);
    clk_select = 1'b0;
    repeat (5) @(negedge clk);
    clk_step = 1'b1;
    repeat (10) @(negedge clk);
    clk_select = 1'b1;
    repeat (5) @(negedge clk);
    chk("held_entry_busy", 32'(busy), 1);
    chk("held_entry_en", 32'(cpu_en), 0);
    clk_step = 1'b0;
    repeat (10) @(negedge clk);
    chk("held_rel_busy", 32'(busy), 0);
    chk("held_count", 32'(step_count), 2);
    press(6, 10, 1);
    chk("after_held", 32'(step_count), 3);

    begin
      exp_t e;
      @(negedge clk);
      clk_step = 1'b1;
      exp_cnt = exp_cnt + 4'd1;
      e.at  = cyc + 7;
      e.cnt = exp_cnt;
      sb.push_back(e);
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      clk_step = 1'b0;
      edges(1);
      chk("rst_pulse_en", 32'(cpu_en), 0);
      chk("rst_pulse_cnt", 32'(step_count), 0);
      chk("rst_pulse_busy", 32'(busy), 0);
      exp_cnt = 4'd0;
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("post_rst_cnt", 32'(step_count), 0);
      chk("post_rst_mode", 32'(step_mode), 1);
    end

    for (int k = 0; k < 16; k++) press(6, 10, 1);
    chk("wrap_0", 32'(step_count), 0);
    press(6, 10, 1);
    chk("wrap_1", 32'(step_count), 1);

    budget = 0;
    while (sb.size() != 0 && budget < 50) begin
      @(posedge clk);
      budget++;
    end
    #2;
    chk("sb_drained", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
